// File: rtl/bus_ctrl8086.sv
// Minimum-mode 8086 bus controller: latches the demultiplexed address on ALE and
// turns each RD/WR strobe into one req/ack transaction, holding READY low meanwhile.
module bus_ctrl8086 #(
    parameter int WAIT_STATES = 0,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        ale,
    input  logic        m_ioN,
    input  logic        dt_rN,
    input  logic        denN,
    input  logic        bheN,
    input  logic        rdN,
    input  logic        wrN,
    input  logic [3:0]  asbus,
    input  logic [15:0] adbus_in,
    output logic [15:0] adbus_out,
    output logic        adbus_oe,
    output logic        ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [19:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_WAIT  = 3'd2,
        S_REQ   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0]  WS_LOAD  = 4'(WAIT_STATES);
    localparam logic [16:0] TO_LIMIT = 17'(ACK_TIMEOUT);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [15:0] to_cnt;

    // Memory handshake: mem_req rises once per CPU cycle and stays high until a
    // single-cycle mem_ack is sampled in REQ or the timeout fires; acks seen in any
    // other state are ignored, and only one transaction is ever outstanding.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= S_IDLE;
            ready     <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_io    <= 1'b0;
            mem_addr  <= 20'h0;
            mem_be    <= 2'b00;
            mem_wdata <= 16'h0;
            adbus_out <= 16'h0;
            bus_err   <= 1'b0;
            wait_cnt  <= 4'd0;
            to_cnt    <= 16'd0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ale) begin
                        mem_addr <= {asbus, adbus_in};
                        mem_io   <= ~m_ioN;
                        mem_be   <= {~bheN, ~adbus_in[0]};
                        ready    <= 1'b0;
                        state    <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (!rdN || !wrN) begin
                        // rdN low wins, so both strobes low is handled as a read.
                        mem_we <= rdN;
                        if (rdN) begin
                            mem_wdata <= adbus_in;
                        end
                        if (mem_be == 2'b00) begin
                            if (!rdN) begin
                                adbus_out <= 16'hFFFF;
                            end
                            ready <= 1'b1;
                            state <= S_DONE;
                        end else if (WAIT_STATES > 0) begin
                            wait_cnt <= WS_LOAD;
                            state    <= S_WAIT;
                        end else begin
                            to_cnt  <= 16'd0;
                            mem_req <= 1'b1;
                            state   <= S_REQ;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        wait_cnt <= 4'd0;
                        to_cnt   <= 16'd0;
                        mem_req  <= 1'b1;
                        state    <= S_REQ;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        ready   <= 1'b1;
                        if (!mem_we) begin
                            adbus_out <= mem_rdata;
                        end
                        state <= S_DONE;
                    end else if (({1'b0, to_cnt} + 17'd1) == TO_LIMIT) begin
                        // Counter is compared one ahead so it stops at the limit and never wraps.
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        ready   <= 1'b1;
                        if (!mem_we) begin
                            adbus_out <= 16'hFFFF;
                        end
                        state <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    if (rdN && wrN) begin
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read data is driven only while the CPU is actually strobing a read in DONE.
    assign adbus_oe  = (state == S_DONE) & ~mem_we & ~rdN & ~denN & ~dt_rN;
    assign dbg_state = state;

endmodule

// File: tb/tb_bus_ctrl8086.sv
// Bench for bus_ctrl8086: table of directed CPU cycles, hand-written wait-state and
// reset sequences, and randomized cycles checked against a transaction-level model.
module tb_bus_ctrl8086;

    localparam int AT0     = 8;
    localparam int WS1     = 3;
    localparam int ST_IDLE = 0;

    logic        clk = 1'b0;
    logic        resetN;
    logic        ale, m_ioN, dt_rN, denN, bheN, rdN, wrN;
    logic [3:0]  asbus;
    logic [15:0] adbus_in;

    logic [15:0] adbus_out, mem_wdata, mem_rdata;
    logic        adbus_oe, ready, mem_req, mem_we, mem_io, mem_ack, bus_err;
    logic [19:0] mem_addr;
    logic [1:0]  mem_be;
    logic [2:0]  dbg_state;

    logic [15:0] adbus_out_1, mem_wdata_1, mem_rdata_1;
    logic        adbus_oe_1, ready_1, mem_req_1, mem_we_1, mem_io_1, mem_ack_1, bus_err_1;
    logic [19:0] mem_addr_1;
    logic [1:0]  mem_be_1;
    logic [2:0]  dbg_state_1;

    int n_chk  = 0;
    int n_pass = 0;
    logic [39:0] exp_q[$];

    typedef struct {
        logic [19:0] addr;
        logic        io;
        logic        bhe_n;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          ack_delay;
        logic [1:0]  exp_be;
        int          exp_req_cycles;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl[8];

    bus_ctrl8086 #(.WAIT_STATES(0), .ACK_TIMEOUT(AT0)) dut (
        .clk(clk), .resetN(resetN), .ale(ale), .m_ioN(m_ioN), .dt_rN(dt_rN),
        .denN(denN), .bheN(bheN), .rdN(rdN), .wrN(wrN), .asbus(asbus),
        .adbus_in(adbus_in), .adbus_out(adbus_out), .adbus_oe(adbus_oe),
        .ready(ready), .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err),
        .dbg_state(dbg_state)
    );

    bus_ctrl8086 #(.WAIT_STATES(WS1), .ACK_TIMEOUT(20)) dut_ws (
        .clk(clk), .resetN(resetN), .ale(ale), .m_ioN(m_ioN), .dt_rN(dt_rN),
        .denN(denN), .bheN(bheN), .rdN(rdN), .wrN(wrN), .asbus(asbus),
        .adbus_in(adbus_in), .adbus_out(adbus_out_1), .adbus_oe(adbus_oe_1),
        .ready(ready_1), .mem_req(mem_req_1), .mem_we(mem_we_1), .mem_io(mem_io_1),
        .mem_addr(mem_addr_1), .mem_be(mem_be_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .mem_ack(mem_ack_1), .bus_err(bus_err_1),
        .dbg_state(dbg_state_1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        ale = 1'b0; m_ioN = 1'b1; dt_rN = 1'b0; denN = 1'b1; bheN = 1'b1;
        rdN = 1'b1; wrN = 1'b1; asbus = 4'h0; adbus_in = 16'h0;
        mem_ack = 1'b0; mem_rdata = 16'h0;
    endtask

    task automatic apply_reset();
        resetN = 1'b0;
        bus_idle();
        repeat (2) tick();
        resetN = 1'b1;
        tick();
    endtask

    // Second instance's memory: acks one cycle after it sees mem_req.
    initial begin
        mem_ack_1   = 1'b0;
        mem_rdata_1 = 16'hC0DE;
        forever begin
            @(posedge clk);
            #2;
            mem_ack_1 = mem_req_1 && !mem_ack_1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_addr(input logic [19:0] addr, input logic io, input logic bhe_n,
                            input logic wr);
        ale = 1'b1; asbus = addr[19:16]; adbus_in = addr[15:0];
        m_ioN = ~io; bheN = bhe_n; dt_rN = wr; denN = 1'b1; rdN = 1'b1; wrN = 1'b1;
        tick();
        ale = 1'b0;
    endtask

    task automatic bus_cmd(input logic wr, input logic [15:0] wdata);
        adbus_in = wr ? wdata : 16'($urandom);
        denN = 1'b0;
        if (wr) wrN = 1'b0;
        else    rdN = 1'b0;
        tick();
    endtask

    task automatic run_txn(input vec_t v);
        int n;
        logic [39:0] w;
        if (v.exp_req_cycles > 0)
            exp_q.push_back({v.io, v.wr, v.exp_be, v.addr, v.wr ? v.wdata : 16'h0});
        bus_addr(v.addr, v.io, v.bhe_n, v.wr);
        chk("ready_fall", 40'(ready), 40'(1'b0));
        chk("addr_latch", 40'(mem_addr), 40'(v.addr));
        chk("be_latch", 40'(mem_be), 40'(v.exp_be));
        bus_cmd(v.wr, v.wdata);
        if (v.exp_req_cycles == 0) begin
            chk("no_req", 40'(mem_req), 40'(1'b0));
            chk("ready_nolane", 40'(ready), 40'(1'b1));
        end else begin
            chk("req_latency", 40'(mem_req), 40'(1'b1));
            chk("ready_hold", 40'(ready), 40'(1'b0));
            if (mem_req && exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("txn", {mem_io, mem_we, mem_be, mem_addr, mem_we ? mem_wdata : 16'h0}, w);
            end
            n = 0;
            while (mem_req && n < 100) begin
                mem_ack   = (n == v.ack_delay);
                mem_rdata = mem_ack ? v.rdata : 16'($urandom);
                tick();
                n++;
            end
            mem_ack = 1'b0;
            chk("req_cycles", 40'(n), 40'(v.exp_req_cycles));
            chk("bus_err", 40'(bus_err), 40'(v.exp_err));
            chk("ready_rise", 40'(ready), 40'(1'b1));
        end
        if (!v.wr) begin
            chk("rdata", 40'(adbus_out), 40'(v.exp_rdata));
            chk("oe_on", 40'(adbus_oe), 40'(1'b1));
        end else begin
            chk("oe_off_wr", 40'(adbus_oe), 40'(1'b0));
        end
        rdN = 1'b1; wrN = 1'b1; denN = 1'b1;
        tick();
        chk("back_idle", 40'(dbg_state), 40'(ST_IDLE));
        chk("ready_idle", 40'(ready), 40'(1'b1));
        chk("err_pulse", 40'(bus_err), 40'(1'b0));
        chk("oe_idle", 40'(adbus_oe), 40'(1'b0));
    endtask

    // Transaction-level reference: lanes from BHE/A0, then ack-vs-timeout arithmetic.
    task automatic gen_random(output vec_t v);
        logic active;
        v.addr      = 20'($urandom);
        v.io        = 1'($urandom_range(0, 1));
        v.bhe_n     = 1'($urandom_range(0, 1));
        v.wr        = 1'($urandom_range(0, 1));
        v.wdata     = 16'($urandom);
        v.rdata     = 16'($urandom);
        v.ack_delay = $urandom_range(0, 11);
        v.exp_be    = {~v.bhe_n, ~v.addr[0]};
        active      = (v.exp_be != 2'b00);
        v.exp_req_cycles = !active ? 0 : ((v.ack_delay < AT0) ? v.ack_delay + 1 : AT0);
        v.exp_err   = active && (v.ack_delay >= AT0);
        v.exp_rdata = (active && v.ack_delay < AT0) ? v.rdata : 16'hFFFF;
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        int lat;

        //            addr      io    bhe_n wr    wdata     rdata     dly be     req err   rdata
        tbl[0] = '{20'h12340, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 1,  2'b11, 2, 1'b0, 16'hBEEF};
        tbl[1] = '{20'h00061, 1'b1, 1'b0, 1'b1, 16'h5A00, 16'h0000, 0,  2'b10, 1, 1'b0, 16'h0000};
        tbl[2] = '{20'h4F000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7777, 30, 2'b11, 8, 1'b1, 16'hFFFF};
        tbl[3] = '{20'h00001, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1111, 0,  2'b00, 0, 1'b0, 16'hFFFF};
        tbl[4] = '{20'hFFFFE, 1'b0, 1'b1, 1'b1, 16'h00A5, 16'h0000, 3,  2'b01, 4, 1'b0, 16'h0000};
        tbl[5] = '{20'h80004, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, 7,  2'b11, 8, 1'b0, 16'h1234};
        tbl[6] = '{20'h00100, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h4321, 8,  2'b11, 8, 1'b1, 16'hFFFF};
        tbl[7] = '{20'h00003, 1'b1, 1'b1, 1'b1, 16'hABCD, 16'h0000, 0,  2'b00, 0, 1'b0, 16'h0000};

        resetN = 1'b0;
        bus_idle();
        repeat (2) tick();
        chk("rst_ready", 40'(ready), 40'(1'b1));
        chk("rst_req", 40'(mem_req), 40'(1'b0));
        chk("rst_regs", {mem_we, mem_io, mem_be, mem_addr, mem_wdata}, 40'h0);
        chk("rst_bus", {adbus_out, adbus_oe, bus_err}, 40'h0);
        chk("rst_state", 40'(dbg_state), 40'(ST_IDLE));
        resetN = 1'b1;
        tick();

        // Wait-state instance: mem_req must come 1 + WS1 edges after the command edge.
        bus_addr(20'h0A002, 1'b0, 1'b0, 1'b0);
        bus_cmd(1'b0, 16'h0);
        chk("ws_no_early_req", 40'(mem_req_1), 40'(1'b0));
        lat = 1;
        while (!mem_req_1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("ws_latency", 40'(lat), 40'(1 + WS1));
        lat = 0;
        while (!ready_1 && lat < 10) begin
            tick();
            lat++;
        end
        chk("ws_ready", 40'(ready_1), 40'(1'b1));
        chk("ws_rdata", 40'(adbus_out_1), 40'(16'hC0DE));
        chk("ws_oe", 40'(adbus_oe_1), 40'(1'b1));
        apply_reset();

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i]);
            tick();
        end

        // Reset while a write is waiting in REQ: everything clears before the next edge.
        bus_addr(20'h35557, 1'b1, 1'b0, 1'b1);
        bus_cmd(1'b1, 16'h9C3E);
        chk("mid_req_up", 40'(mem_req), 40'(1'b1));
        #2;
        resetN = 1'b0;
        #1;
        chk("mid_rst_req", 40'(mem_req), 40'(1'b0));
        chk("mid_rst_ready", 40'(ready), 40'(1'b1));
        chk("mid_rst_regs", {mem_we, mem_io, mem_be, mem_addr, mem_wdata}, 40'h0);
        chk("mid_rst_bus", {adbus_out, adbus_oe, bus_err}, 40'h0);
        chk("mid_rst_state", 40'(dbg_state), 40'(ST_IDLE));
        bus_idle();
        tick();
        resetN = 1'b1;
        tick();
        run_txn(tbl[0]);

        apply_reset();
        for (int i = 0; i < 40; i++) begin
            gen_random(v);
            run_txn(v);
            repeat ($urandom_range(1, 3)) begin
                mem_ack = 1'($urandom_range(0, 1));
                tick();
                chk("idle_ack_ignored", {mem_req, ready}, 40'(2'b01));
            end
            mem_ack = 1'b0;
        end

        chk("exp_q_drained", 40'(exp_q.size()), 40'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
